sync_filter_bank: RTL

SYNC_FILTER_BANK -- requirements
Module: sync_filter_bank

---
 rtl/sync_filter_bank.sv | 99 +++++++++
 1 files changed

// File: rtl/sync_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : sync_filter_bank
// Brief    : Per-channel multi-flop synchronizer with a tick-qualified glitch
//            filter and registered rise/fall pulses.
//            Define SYNC_FILTER_GLITCH_EN to compile in the counter filter;
//            otherwise data_out is a plain register of data_sync.
// Revision : 1.0 - initial release
// ============================================================================
module sync_filter_bank #(
    parameter int                NUM_CH     = 8,
    parameter int                NUM_STAGES = 3,
    parameter int                FILTER_LEN = 4,
    parameter logic [NUM_CH-1:0] RESET_VAL  = {NUM_CH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] data_in,
    input  logic              tick,
    output logic [NUM_CH-1:0] data_sync,
    output logic [NUM_CH-1:0] data_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
);

    logic [NUM_CH-1:0] r_sync [NUM_STAGES];
    logic [NUM_CH-1:0] r_out;
    logic [NUM_CH-1:0] r_rise;
    logic [NUM_CH-1:0] r_fall;
    logic [NUM_CH-1:0] w_out_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_sync[s] <= RESET_VAL;
            end
        end else begin
            r_sync[0] <= data_in;
            for (int s = 1; s < NUM_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign data_sync = r_sync[NUM_STAGES-1];

`ifdef SYNC_FILTER_GLITCH_EN
    localparam int               CNT_W      = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             w_mis;
            logic             w_accept;

            assign w_mis    = data_sync[i] ^ r_out[i];
            assign w_accept = w_mis & tick & (r_cnt == C_CNT_LAST);

            // Any agreement between input and output wipes the partial run.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (!w_mis || w_accept) begin
                    r_cnt <= '0;
                end else if (tick) begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end

            assign w_out_nxt[i] = w_accept ? data_sync[i] : r_out[i];
        end
    endgenerate
`else
    logic w_unused_tick;
    assign w_unused_tick = tick;
    assign w_out_nxt     = data_sync;
`endif

    // Pulses compare next vs current level, so reset jumps never pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out  <= RESET_VAL;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_out  <= w_out_nxt;
            r_rise <= w_out_nxt & ~r_out;
            r_fall <= ~w_out_nxt & r_out;
        end
    end

    assign data_out = r_out;
    assign rise     = r_rise;
    assign fall     = r_fall;

endmodule
`default_nettype wire
